// File: rtl/fpu_pipe_pkg.sv
// Shared constants and arithmetic for the fpu_pipe_wrap retiming wrapper.
// The add/mul core is modelled as pure functions so the surrounding stages can be retimed into it.
package fpu_pipe_pkg;

  localparam logic [1:0]  OP_ADD   = 2'b00;
  localparam logic [1:0]  OP_MUL   = 2'b01;
  localparam logic        FMT_FP32 = 1'b0;
  localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;

  function automatic int fpu_lat(input int pre_pipe, input int core_lat, input int post_pipe);
    return pre_pipe + core_lat + post_pipe;
  endfunction

  // m: bit 26 is the hidden one, [25:3] fraction, [2] guard, [1] round, [0] sticky.
  function automatic logic [31:0] fp_pack(input logic s, input int e_in, input logic [26:0] m);
    logic [24:0] mant;
    logic        up;
    int          e;
    e    = e_in;
    up   = m[2] && (m[1] || m[0] || m[3]);
    mant = {1'b0, m[26:3]} + 25'(up);
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (e <= 0)   return {s, 31'd0};
    return {s, 8'(e), mant[22:0]};
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic [47:0] p;
    logic [26:0] m;
    int          e;
    s = x[31] ^ y[31];
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return FP_QNAN;
    if (x[30:23] == 8'h00 || y[30:23] == 8'h00) return {s, 31'd0};
    p = 48'({1'b1, x[22:0]}) * 48'({1'b1, y[22:0]});
    e = int'(x[30:23]) + int'(y[30:23]) - 127;
    if (p[47]) begin
      m = {p[47:22], |p[21:0]};
      e = e + 1;
    end else begin
      m = {p[46:21], |p[20:0]};
    end
    return fp_pack(s, e, m);
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b;
    logic [26:0] ma, mb, sh, mk, m;
    logic [27:0] sum;
    int          d, e;
    if (x[30:23] == 8'hFF || y[30:23] == 8'hFF) return FP_QNAN;
    if (x[30:23] == 8'h00) return (y[30:23] == 8'h00) ? 32'd0 : y;
    if (y[30:23] == 8'h00) return x;
    if (x[30:0] >= y[30:0]) begin a = x; b = y; end
    else                    begin a = y; b = x; end
    d  = int'(a[30:23]) - int'(b[30:23]);
    e  = int'(a[30:23]);
    ma = {1'b1, a[22:0], 3'b000};
    mb = {1'b1, b[22:0], 3'b000};
    if (d > 26) begin
      sh = 27'd1;
    end else begin
      mk = (27'd1 << d) - 27'd1;
      sh = (mb >> d) | 27'(|(mb & mk));
    end
    if (a[31] == b[31]) begin
      sum = {1'b0, ma} + {1'b0, sh};
      if (sum[27]) begin
        m = {sum[27:2], |sum[1:0]};
        e = e + 1;
      end else begin
        m = sum[26:0];
      end
    end else begin
      m = ma - sh;
      if (m == 27'd0) return 32'd0;
      for (int i = 0; i < 26; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 1;
        end
      end
    end
    return fp_pack(a[31], e, m);
  endfunction

  function automatic logic [31:0] fp_core(input logic [1:0] op, input logic fmt,
                                          input logic [31:0] x, input logic [31:0] y);
    if (fmt != FMT_FP32) return FP_QNAN;
    case (op)
      OP_ADD:  return fp_add(x, y);
      OP_MUL:  return fp_mul(x, y);
      default: return FP_QNAN;
    endcase
  endfunction

endpackage

// File: rtl/fpu_pipe_fifo.sv
// Show-ahead result FIFO; pointers wrap modulo DEPTH so any depth >= 1 works.
module fpu_pipe_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same edge, so a push onto a full FIFO is fine then.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fpu_pipe_wrap.sv
// Valid/ready retiming wrapper around the FP add/mul core with a credit-guarded result FIFO.
// Optional statistics counters are enabled with `define FPU_PIPE_STATS_EN.
module fpu_pipe_wrap
  import fpu_pipe_pkg::*;
#(
  parameter int PRE_PIPE   = 0,
  parameter int CORE_LAT   = 0,
  parameter int POST_PIPE  = 1,
  parameter int TAG_W      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic             in_fmt,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_r,
  output logic [TAG_W-1:0] out_tag
`ifdef FPU_PIPE_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [31:0]      stat_ops,
  output logic [31:0]      stat_stall
`endif
);
  localparam int L  = fpu_lat(PRE_PIPE, CORE_LAT, POST_PIPE);
  localparam int PD = CORE_LAT + POST_PIPE;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  generate
    if (FIFO_DEPTH < 1) begin : g_bad_depth
      $fatal(1, "fpu_pipe_wrap: FIFO_DEPTH must be >= 1");
    end
    if (PRE_PIPE < 0 || PRE_PIPE > 4 || POST_PIPE < 0 || POST_PIPE > 4) begin : g_bad_pipe
      $fatal(1, "fpu_pipe_wrap: PRE_PIPE/POST_PIPE must be 0..4");
    end
  endgenerate

  typedef struct packed {
    logic [1:0]       op;
    logic             fmt;
    logic [31:0]      x;
    logic [31:0]      y;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [31:0]      r;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic          acc, pop;
  logic [CW-1:0] credits;
  logic [L:0]    vld_pipe;
  req_t          req_in, req_core;
  res_t          res_core, res_out, fifo_dout;
  logic          fifo_full, fifo_empty;

  assign in_ready = !rst && (credits != '0);
  assign acc      = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Credits count in-flight ops plus FIFO occupancy, so the FIFO can never overflow.
  always_ff @(posedge clk) begin
    if (rst)               credits <= CW'(FIFO_DEPTH);
    else if (acc && !pop)  credits <= credits - CW'(1);
    else if (pop && !acc)  credits <= credits + CW'(1);
  end

  assign vld_pipe[0] = acc;
  generate
    if (L > 0) begin : g_vld
      always_ff @(posedge clk) begin
        if (rst) vld_pipe[L:1] <= '0;
        else     vld_pipe[L:1] <= vld_pipe[L-1:0];
      end
    end
  endgenerate

  assign req_in = '{op: in_opcode, fmt: in_fmt, x: in_x, y: in_y, tag: in_tag};

  // Data stages carry no reset so synthesis is free to retime them across the core.
  generate
    if (PRE_PIPE == 0) begin : g_pre_wire
      assign req_core = req_in;
    end else begin : g_pre
      req_t pre_q [PRE_PIPE];
      always_ff @(posedge clk) begin
        pre_q[0] <= req_in;
        for (int i = 1; i < PRE_PIPE; i++) pre_q[i] <= pre_q[i-1];
      end
      assign req_core = pre_q[PRE_PIPE-1];
    end
  endgenerate

  assign res_core = '{r: fp_core(req_core.op, req_core.fmt, req_core.x, req_core.y),
                      tag: req_core.tag};

  // Core latency and post stages form one result delay line.
  generate
    if (PD == 0) begin : g_post_wire
      assign res_out = res_core;
    end else begin : g_post
      res_t post_q [PD];
      always_ff @(posedge clk) begin
        post_q[0] <= res_core;
        for (int i = 1; i < PD; i++) post_q[i] <= post_q[i-1];
      end
      assign res_out = post_q[PD-1];
    end
  endgenerate

  fpu_pipe_fifo #(
    .WIDTH (32 + TAG_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[L]),
    .din   (res_out),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_r     = fifo_dout.r;
  assign out_tag   = fifo_dout.tag;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(vld_pipe[L] && fifo_full && !pop));

`ifdef FPU_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (pop && stat_ops != '1)                    stat_ops   <= stat_ops + 32'd1;
      if (in_valid && !in_ready && stat_stall != '1) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fpu_pipe_wrap.sv
// Scoreboard bench for fpu_pipe_wrap: integer-valued float ops give exact reference results.
module tb_fpu_pipe_wrap;
  import fpu_pipe_pkg::*;

  localparam int TW    = 5;
  localparam int DEPTH = 4;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_fmt = FMT_FP32, out_ready = 1'b0;
  logic [1:0]    in_opcode = OP_ADD;
  logic [31:0]   in_x = '0, in_y = '0;
  logic [TW-1:0] in_tag = '0;
  logic          in_ready, out_valid;
  logic [31:0]   out_r;
  logic [TW-1:0] out_tag;
`ifdef FPU_PIPE_STATS_EN
  logic          stat_clr = 1'b0;
  logic [31:0]   stat_ops, stat_stall;
`endif

  fpu_pipe_wrap #(
    .PRE_PIPE(0), .CORE_LAT(0), .POST_PIPE(1), .TAG_W(TW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_fmt(in_fmt),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r), .out_tag(out_tag)
`ifdef FPU_PIPE_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int acc_cnt = 0, pop_cnt = 0;
  logic [31:0]      drv_exp = '0;
  logic [TW+31:0]   exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] to_fp(input int v);
    int          a, p;
    logic [31:0] t;
    if (v == 0) return 32'd0;
    a = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (a >= (1 << i)) p = i;
    t = 32'(a << (23 - p));
    return {v < 0, 8'(127 + p), t[22:0]};
  endfunction

  // Monitor: ready follows outstanding count; pops compare against the acceptance-order queue.
  always @(negedge clk) begin
    logic [TW+31:0] e;
    if (!rst) begin
      check("in_ready_credit", in_ready, exp_q.size() < DEPTH);
      if (out_valid && out_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_result: got r=%h tag=%0d with nothing outstanding", out_r, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("out_r", out_r, e[31:0]);
          check("out_tag", 32'(out_tag), 32'(e[TW+31:32]));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, drv_exp});
        acc_cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [TW-1:0] tag, input logic [31:0] exp);
    in_opcode = op; in_x = x; in_y = y; in_tag = tag; drv_exp = exp;
  endtask

  task automatic rand_op(input logic [TW-1:0] tag);
    int a, b;
    logic [31:0] x;
    case ($urandom_range(0, 2))
      0: begin
        a = $urandom_range(1, 1 << 20); if ($urandom_range(0, 1) == 1) a = -a;
        b = $urandom_range(1, 1 << 20); if ($urandom_range(0, 1) == 1) b = -b;
        set_op(OP_ADD, to_fp(a), to_fp(b), tag, to_fp(a + b));
      end
      1: begin
        a = $urandom_range(1, 2047); if ($urandom_range(0, 1) == 1) a = -a;
        b = $urandom_range(1, 2047);
        set_op(OP_MUL, to_fp(a), to_fp(b), tag, to_fp(a * b));
      end
      default: begin
        x = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
        set_op(OP_MUL, x, 32'h3F80_0000, tag, x);
      end
    endcase
  endtask

  initial begin
    int a0, n;
    rst = 1'b1;
    repeat (2) step();
    check("in_ready_in_reset", in_ready, 0);
    check("out_valid_in_reset", out_valid, 0);
    rst = 1'b0;
    #1 check("in_ready_after_reset", in_ready, 1);

    // 1.0 + 2.0, tag 5: visible after the second edge
    set_op(OP_ADD, 32'h3F80_0000, 32'h4000_0000, 5, 32'h4040_0000);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_early", out_valid, 0);
    step();
    check("lat_valid", out_valid, 1);
    check("lat_r", out_r, 32'h4040_0000);
    check("lat_tag", 32'(out_tag), 5);
    step();

    // 20 back-to-back x*1.0 ops
    for (int i = 0; i <= 22; i++) begin
      if (i < 20) begin
        rand_op(TW'(i));
        set_op(OP_MUL, in_x, 32'h3F80_0000, TW'(i), in_x);
        in_valid = 1'b1;
        check("stream_ready", in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      check("stream_valid", out_valid, (i >= 2 && i <= 21));
      step();
    end

    // Back-pressure: four credits then stall
    out_ready = 1'b0; in_valid = 1'b1; a0 = acc_cnt;
    for (int i = 0; i < 8; i++) begin rand_op(TW'(i)); step(); end
    check("bp_accepts", acc_cnt - a0, 4);
    check("bp_ready_low", in_ready, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_ready_back", in_ready, 1);
    a0 = acc_cnt;
    for (int i = 0; i < 4; i++) begin rand_op(TW'(8 + i)); step(); end
    check("bp_one_more", acc_cnt - a0, 1);

    // Random traffic, including pops coinciding with arrivals on a full FIFO
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rand_op(TW'($urandom));
      step();
    end

    // Reset with work in flight and queued
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_op(TW'(i)); step(); end
    rst = 1'b1; in_valid = 1'b0;
    exp_q.delete();
    step();
    check("mid_rst_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("post_rst_no_valid", out_valid, 0);
      step();
    end
    in_valid = 1'b1; a0 = acc_cnt;
    for (int i = 0; i < 6; i++) begin rand_op(TW'(i)); step(); end
    check("post_rst_accepts", acc_cnt - a0, 4);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin step(); n++; end
    check("drain_empty", exp_q.size(), 0);

`ifdef FPU_PIPE_STATS_EN
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("stat_clr_ops", stat_ops, 0);
    check("stat_clr_stall", stat_stall, 0);
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin rand_op(TW'(i)); step(); end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) step();
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin rand_op(TW'(i)); step(); end
    in_valid = 1'b0;
    repeat (6) step();
    check("stat_ops", stat_ops, 10);
    check("stat_stall", stat_stall, 3);
    stat_clr = 1'b1; step(); stat_clr = 1'b0;
    check("stat_ops_cleared", stat_ops, 0);
    check("stat_stall_cleared", stat_stall, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
